// File: rtl/rs_alloc_issue.sv
// rs_alloc_issue: allocate / wakeup / issue buffer with lowest-index priority selection.
// Optional macro RS_FREECNT_EN adds the registered free-entry counter output free_cnt.
module rs_alloc_issue #(
  parameter int ENTSEL = 2,
  parameter int ENTNUM = 4,
  parameter int DATAW  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATAW-1:0]  wdata,
  input  logic              wready,
  output logic              alloc_ok,
  output logic [ENTSEL-1:0] alloc_idx,
  output logic              full,
  input  logic              wakeup_en,
  input  logic [ENTSEL-1:0] wakeup_idx,
  output logic              issue_valid,
  output logic [ENTSEL-1:0] issue_idx,
  output logic [DATAW-1:0]  issue_data,
  input  logic              issue_ack
`ifdef RS_FREECNT_EN
  ,
  output logic [ENTSEL:0]   free_cnt
`endif
);

  logic [ENTNUM-1:0] busy_q, busy_d;
  logic [ENTNUM-1:0] ready_q, ready_d;
  logic [DATAW-1:0]  payload_q [ENTNUM];
  logic [DATAW-1:0]  payload_d [ENTNUM];
  logic [ENTNUM-1:0] free_vec;
  logic [ENTNUM-1:0] issue_vec;
  logic              issue_fire;

  always_comb begin
    free_vec    = ~busy_q;
    issue_vec   = busy_q & ready_q;
    full        = &busy_q;
    issue_valid = |issue_vec;
    alloc_idx   = '0;
    issue_idx   = '0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = ENTNUM - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = ENTSEL'(i);
      if (issue_vec[i]) issue_idx = ENTSEL'(i);
    end
    issue_data = issue_valid ? payload_q[issue_idx] : '0;
    alloc_ok   = we & ~full;
    issue_fire = issue_ack & issue_valid;
  end

  always_comb begin
    busy_d    = busy_q;
    ready_d   = ready_q;
    payload_d = payload_q;
    if (wakeup_en && busy_q[wakeup_idx]) ready_d[wakeup_idx] = 1'b1;
    if (alloc_ok) begin
      busy_d[alloc_idx]    = 1'b1;
      ready_d[alloc_idx]   = wready;
      payload_d[alloc_idx] = wdata;
    end
    // Applied last so an acknowledged entry stays free even if woken this cycle.
    if (issue_fire) begin
      busy_d[issue_idx]  = 1'b0;
      ready_d[issue_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
    payload_q <= payload_d;
  end

`ifdef RS_FREECNT_EN
  logic [ENTSEL:0] free_cnt_q, free_cnt_d;

  always_comb begin
    free_cnt_d = free_cnt_q;
    if (alloc_ok && !issue_fire) free_cnt_d = free_cnt_q - (ENTSEL+1)'(1);
    else if (issue_fire && !alloc_ok) free_cnt_d = free_cnt_q + (ENTSEL+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) free_cnt_q <= (ENTSEL+1)'(ENTNUM);
    else        free_cnt_q <= free_cnt_d;
  end

  assign free_cnt = free_cnt_q;
`endif

endmodule

// File: tb/tb_rs_alloc_issue.sv
// Self-checking bench for rs_alloc_issue: directed scenarios plus randomized traffic
// compared every cycle against an entry-array reference model.
module tb_rs_alloc_issue;

  localparam int ENTSEL = 2;
  localparam int ENTNUM = 4;
  localparam int DATAW  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              we = 1'b0;
  logic [DATAW-1:0]  wdata = '0;
  logic              wready = 1'b0;
  logic              wakeup_en = 1'b0;
  logic [ENTSEL-1:0] wakeup_idx = '0;
  logic              issue_ack = 1'b0;
  logic              alloc_ok;
  logic [ENTSEL-1:0] alloc_idx;
  logic              full;
  logic              issue_valid;
  logic [ENTSEL-1:0] issue_idx;
  logic [DATAW-1:0]  issue_data;
`ifdef RS_FREECNT_EN
  logic [ENTSEL:0]   free_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  rs_alloc_issue #(.ENTSEL(ENTSEL), .ENTNUM(ENTNUM), .DATAW(DATAW)) dut (
    .clk(clk), .reset(reset), .we(we), .wdata(wdata), .wready(wready),
    .alloc_ok(alloc_ok), .alloc_idx(alloc_idx), .full(full),
    .wakeup_en(wakeup_en), .wakeup_idx(wakeup_idx),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_data(issue_data),
    .issue_ack(issue_ack)
`ifdef RS_FREECNT_EN
    , .free_cnt(free_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one record per entry, current and next-edge copies.
  bit               m_busy   [ENTNUM];
  bit               m_ready  [ENTNUM];
  logic [DATAW-1:0] m_data   [ENTNUM];
  bit               n_busy   [ENTNUM];
  bit               n_ready  [ENTNUM];
  logic [DATAW-1:0] n_data   [ENTNUM];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model mid-cycle and work out the model's next state.
  always @(negedge clk) begin : compare
    int e_alloc, e_issue, nfree;
    bit e_full, e_valid, e_aok, got_a, got_i;
    logic [DATAW-1:0] e_data;
    e_alloc = 0; e_issue = 0; nfree = 0; got_a = 0; got_i = 0;
    for (int i = 0; i < ENTNUM; i++) begin
      if (!m_busy[i]) begin
        nfree++;
        if (!got_a) begin e_alloc = i; got_a = 1; end
      end
      if (m_busy[i] && m_ready[i] && !got_i) begin e_issue = i; got_i = 1; end
    end
    e_full  = (nfree == 0);
    e_valid = got_i;
    e_data  = e_valid ? m_data[e_issue] : '0;
    e_aok   = we && !e_full;
    if (chk_en) begin
      checkOutput("alloc_ok",    64'(alloc_ok),    64'(e_aok));
      checkOutput("alloc_idx",   64'(alloc_idx),   64'(e_alloc));
      checkOutput("full",        64'(full),        64'(e_full));
      checkOutput("issue_valid", 64'(issue_valid), 64'(e_valid));
      checkOutput("issue_idx",   64'(issue_idx),   64'(e_issue));
      checkOutput("issue_data",  64'(issue_data),  64'(e_data));
`ifdef RS_FREECNT_EN
      checkOutput("free_cnt",    64'(free_cnt),    64'(nfree));
`endif
    end
    n_busy = m_busy; n_ready = m_ready; n_data = m_data;
    if (!reset) begin
      for (int i = 0; i < ENTNUM; i++) begin n_busy[i] = 0; n_ready[i] = 0; end
    end else begin
      if (wakeup_en && m_busy[wakeup_idx]) n_ready[wakeup_idx] = 1;
      if (e_aok) begin
        n_busy[e_alloc] = 1; n_ready[e_alloc] = wready; n_data[e_alloc] = wdata;
      end
      if (issue_ack && e_valid) begin n_busy[e_issue] = 0; n_ready[e_issue] = 0; end
    end
  end

  always @(posedge clk) begin
    m_busy = n_busy; m_ready = n_ready; m_data = n_data;
  end

  task automatic applyStimulus(input bit rst_n, input bit w, input logic [DATAW-1:0] wd,
                               input bit wr, input bit wk, input int wki, input bit ack);
    @(posedge clk);
    #1;
    reset = rst_n; we = w; wdata = wd; wready = wr;
    wakeup_en = wk; wakeup_idx = ENTSEL'(wki); issue_ack = ack;
    @(negedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_full",  64'(full), 0);
    checkOutput("rst_valid", 64'(issue_valid), 0);
    checkOutput("rst_aidx",  64'(alloc_idx), 0);
    checkOutput("rst_iidx",  64'(issue_idx), 0);
    checkOutput("rst_idata", 64'(issue_data), 0);
`ifdef RS_FREECNT_EN
    checkOutput("rst_fcnt",  64'(free_cnt), 4);
`endif
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, DATAW'(32'h10 + i), 0, 0, 0, 0);
      checkOutput("fill_aidx", 64'(alloc_idx), 64'(i));
      checkOutput("fill_aok",  64'(alloc_ok), 1);
    end
    applyStimulus(1, 1, 32'h55, 1, 0, 0, 0);
    checkOutput("full_set",   64'(full), 1);
    checkOutput("full_noiss", 64'(issue_valid), 0);
    checkOutput("full_rej",   64'(alloc_ok), 0);
`ifdef RS_FREECNT_EN
    checkOutput("full_fcnt",  64'(free_cnt), 0);
`endif
    applyStimulus(1, 1, 32'h56, 1, 0, 0, 1);
    checkOutput("full_rej_ack", 64'(alloc_ok), 0);
    applyStimulus(1, 0, 0, 0, 1, 2, 0);
    checkOutput("wk_nobypass", 64'(issue_valid), 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0);
    checkOutput("wk2_valid", 64'(issue_valid), 1);
    checkOutput("wk2_idx",   64'(issue_idx), 2);
    checkOutput("wk2_data",  64'(issue_data), 32'h12);
    applyStimulus(1, 0, 0, 0, 1, 1, 1);
    checkOutput("wk1_idx",   64'(issue_idx), 1);
    checkOutput("wk1_data",  64'(issue_data), 32'h11);
    applyStimulus(1, 1, 32'h21, 0, 0, 0, 0);
    checkOutput("freed_aidx", 64'(alloc_idx), 1);
    checkOutput("freed_aok",  64'(alloc_ok), 1);
    applyStimulus(1, 0, 0, 0, 1, 3, 0);
    checkOutput("pri_idx2", 64'(issue_idx), 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("pri_idx2b", 64'(issue_idx), 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("pri_idx3", 64'(issue_idx), 3);
    applyStimulus(1, 0, 0, 0, 1, 3, 0);
    checkOutput("empty_iss", 64'(issue_valid), 0);
    applyStimulus(1, 1, 32'h32, 0, 0, 0, 0);
    checkOutput("re_aidx2", 64'(alloc_idx), 2);
    applyStimulus(1, 1, 32'h33, 0, 0, 0, 0);
    checkOutput("re_aidx3",   64'(alloc_idx), 3);
    checkOutput("wkfree_ign", 64'(issue_valid), 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("wkfree_ign2", 64'(issue_valid), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("iss0_data", 64'(issue_data), 32'h10);
    applyStimulus(1, 0, 0, 0, 1, 1, 0);
    checkOutput("three_busy", 64'(full), 0);
    applyStimulus(0, 1, 32'h77, 1, 1, 2, 1);
    checkOutput("pre_rst_idx",  64'(issue_idx), 1);
    checkOutput("pre_rst_data", 64'(issue_data), 32'h21);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("mid_rst_full",  64'(full), 0);
    checkOutput("mid_rst_valid", 64'(issue_valid), 0);
    checkOutput("mid_rst_aidx",  64'(alloc_idx), 0);
`ifdef RS_FREECNT_EN
    checkOutput("mid_rst_fcnt",  64'(free_cnt), 4);
`endif
    // Randomized traffic; the bias flips every 64 cycles to reach both full and empty.
    for (int c = 0; c < 3000; c++) begin
      int bias;
      bias = ((c / 64) % 2 == 0) ? 3 : 1;
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 3) < bias),
                    DATAW'($urandom),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0),
                    int'($urandom_range(0, ENTNUM - 1)),
                    ($urandom_range(0, 3) >= bias));
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
